// File: rtl/pipe_ctrl.sv
// Pipeline control for the 5-stage Y86-64 core.
// Generates stall/bubble controls for the F/D/E/M/W pipeline registers,
// sequences BOOT -> RUN -> HALT, and latches the final CPU status.
// Optional macro PERF_CNT_EN adds RUN-only performance counters; when it is
// undefined the counter ports are tied to zero and no counter flops exist.
//
// state  | meaning
// S_BOOT | post-reset flush: F held, D/E/M/W bubbled for BOOT_CYCLES cycles
// S_RUN  | normal hazard handling
// S_HALT | sticky freeze after a non-AOK status reached W; only rst exits
module pipe_ctrl #(
  parameter int BOOT_CYCLES = 5,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [1:0]       m_stat,
  input  logic [1:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             W_bubble,
  output logic             halted,
  output logic [1:0]       cpu_stat,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] R_NONE   = 4'hF;
  // boot timer is a down-counter; reaching zero is the terminal count
  localparam logic [3:0] BOOT_LOAD = 4'(BOOT_CYCLES - 1);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

  state_t     state_q, state_d;
  logic [3:0] boot_cnt_q;
  logic       lu, rt, mp, ex;

  assign lu = (E_icode == I_MRMOVQ || E_icode == I_POPQ) && (E_dstM != R_NONE) &&
              (E_dstM == d_srcA || E_dstM == d_srcB);
  assign rt = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
  assign mp = (E_icode == I_JXX) && !e_Cnd;
  assign ex = (m_stat != STAT_AOK) || (W_stat != STAT_AOK);

  assign halted = (state_q == S_HALT);

  // state register, boot timer and final-status capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_BOOT;
      boot_cnt_q <= BOOT_LOAD;
      cpu_stat   <= STAT_AOK;
    end else begin
      state_q <= state_d;
      if (state_q == S_BOOT && boot_cnt_q != 4'd0)
        boot_cnt_q <= boot_cnt_q - 4'd1;
      if (state_q == S_RUN && W_stat != STAT_AOK)
        cpu_stat <= W_stat;
    end
  end

  // next state and pipeline controls; rst forces the flush pattern immediately
  always_comb begin
    state_d  = state_q;
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    W_stall  = 1'b0;
    W_bubble = 1'b0;
    case (state_q)
      S_BOOT: if (boot_cnt_q == 4'd0) state_d = S_RUN;
      S_RUN:  if (W_stat != STAT_AOK) state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
    if (rst || state_q == S_BOOT) begin
      F_stall  = 1'b1;
      D_bubble = 1'b1;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
      W_bubble = 1'b1;
    end else if (state_q == S_RUN) begin
      F_stall  = lu | rt;
      D_stall  = lu;
      D_bubble = mp | (rt & ~lu);
      E_bubble = mp | lu;
      M_bubble = ex;
      W_stall  = (W_stat != STAT_AOK);
    end else begin
      F_stall  = 1'b1;
      D_stall  = 1'b1;
      W_stall  = 1'b1;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
    end
  end

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] cyc_q, stall_q, mispred_q;

  // RUN-only counters, wrapping naturally at 2^CNT_W
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q     <= '0;
      stall_q   <= '0;
      mispred_q <= '0;
    end else if (state_q == S_RUN) begin
      cyc_q <= cyc_q + CNT_W'(1);
      if (F_stall) stall_q   <= stall_q + CNT_W'(1);
      if (mp)      mispred_q <= mispred_q + CNT_W'(1);
    end
  end

  assign cyc_cnt     = cyc_q;
  assign stall_cnt   = stall_q;
  assign mispred_cnt = mispred_q;
`else
  assign cyc_cnt     = '0;
  assign stall_cnt   = '0;
  assign mispred_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: expected control vectors are queued as each
// step is driven and popped/compared on the following negedge.
module tb_pipe_ctrl;
  localparam int CNT_W = 32;
`ifdef PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, W_bubble, halted, cpu_stat}
  localparam logic [9:0] V_BOOT  = 10'b1011101000;
  localparam logic [9:0] V_IDLE  = 10'b0000000000;
  localparam logic [9:0] V_LU    = 10'b1101000000;
  localparam logic [9:0] V_RT    = 10'b1010000000;
  localparam logic [9:0] V_MP    = 10'b0011000000;
  localparam logic [9:0] V_MPRT  = 10'b1011000000;
  localparam logic [9:0] V_MEX   = 10'b0000100000;
  localparam logic [9:0] V_WEX   = 10'b0000110000;
  localparam logic [9:0] V_HALT  = 10'b1101110110;
  localparam logic [9:0] V_HRST  = 10'b1011101110;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
  logic e_Cnd;
  logic [1:0] m_stat, W_stat;
  logic F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, W_bubble, halted;
  logic [1:0] cpu_stat;
  logic [CNT_W-1:0] cyc_cnt, stall_cnt, mispred_cnt;

  int checks = 0;
  int errors = 0;
  int m_cyc = 0, m_stl = 0, m_mis = 0;

  typedef struct {
    string      tag;
    logic [9:0] exp;
  } exp_t;
  exp_t sb[$];

  wire [9:0] outv = {F_stall, D_stall, D_bubble, E_bubble, M_bubble,
                     W_stall, W_bubble, halted, cpu_stat};

  pipe_ctrl #(.BOOT_CYCLES(5), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
    .M_icode(M_icode), .m_stat(m_stat), .W_stat(W_stat),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
    .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
    .W_bubble(W_bubble), .halted(halted), .cpu_stat(cpu_stat),
    .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic set_nop();
    D_icode = 4'h1; d_srcA = 4'hF; d_srcB = 4'hF;
    E_icode = 4'h1; E_dstM = 4'hF; e_Cnd = 1'b1;
    M_icode = 4'h1; m_stat = 2'd0; W_stat = 2'd0;
  endtask

  // queue expectation, compare at negedge, advance one cycle and update counter model
  task automatic step(input string tag, input logic [9:0] exp, input bit in_run, input bit is_mp);
    exp_t e;
    exp_t g;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
    @(negedge clk);
    g = sb.pop_front();
    checks++;
    assert (outv === g.exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", g.tag, outv, g.exp);
    end
    @(posedge clk);
    if (rst) begin
      m_cyc = 0; m_stl = 0; m_mis = 0;
    end else if (in_run) begin
      m_cyc++;
      if (exp[9]) m_stl++;
      if (is_mp) m_mis++;
    end
    #1;
  endtask

  task automatic check_cnt(input string tag);
    logic [CNT_W-1:0] ec, es, em;
    ec = PERF ? CNT_W'(m_cyc) : '0;
    es = PERF ? CNT_W'(m_stl) : '0;
    em = PERF ? CNT_W'(m_mis) : '0;
    checks++;
    assert ({cyc_cnt, stall_cnt, mispred_cnt} === {ec, es, em}) else begin
      errors++;
      $error("FAIL %s: observed cyc=%0d stall=%0d mispred=%0d expected cyc=%0d stall=%0d mispred=%0d",
             tag, cyc_cnt, stall_cnt, mispred_cnt, ec, es, em);
    end
  endtask

  initial begin
    rst = 1'b1;
    set_nop();
    @(posedge clk); #1;
    step("rst_hold", V_BOOT, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step("boot_flush", V_BOOT, 0, 0);
    step("run_idle", V_IDLE, 1, 0);
    check_cnt("cnt_after_boot");

    E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
    step("lu_mrmov_srcA", V_LU, 1, 0);
    set_nop(); E_icode = 4'hB; E_dstM = 4'h4; d_srcB = 4'h4;
    step("lu_popq_srcB", V_LU, 1, 0);
    set_nop(); E_icode = 4'h5; E_dstM = 4'hF; d_srcA = 4'hF;
    step("lu_dst_none", V_IDLE, 1, 0);
    set_nop(); E_icode = 4'h2; E_dstM = 4'h3; d_srcA = 4'h3;
    step("lu_not_load", V_IDLE, 1, 0);

    set_nop(); D_icode = 4'h9;
    step("ret_in_D", V_RT, 1, 0);
    set_nop(); E_icode = 4'h9;
    step("ret_in_E", V_RT, 1, 0);
    set_nop(); M_icode = 4'h9;
    step("ret_in_M", V_RT, 1, 0);

    set_nop(); E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3; D_icode = 4'h9;
    step("lu_plus_ret", V_LU, 1, 0);

    set_nop(); E_icode = 4'h7; e_Cnd = 1'b0;
    step("mispredict", V_MP, 1, 1);
    check_cnt("cnt_mispredict");
    e_Cnd = 1'b1;
    step("jxx_taken", V_IDLE, 1, 0);
    e_Cnd = 1'b0; D_icode = 4'h9;
    step("mispredict_ret", V_MPRT, 1, 1);

    set_nop(); m_stat = 2'd2;
    step("m_stat_adr", V_MEX, 1, 0);
    set_nop(); W_stat = 2'd2;
    step("w_stat_adr", V_WEX, 1, 0);
    check_cnt("cnt_before_halt");

    set_nop();
    step("halt_entry", V_HALT, 0, 0);
    E_icode = 4'h7; e_Cnd = 1'b0; W_stat = 2'd3; m_stat = 2'd1; D_icode = 4'h9;
    step("halt_sticky", V_HALT, 0, 0);
    check_cnt("cnt_frozen_halt");

    set_nop(); rst = 1'b1;
    step("rst_from_halt", V_HRST, 0, 0);
    rst = 1'b0;
    step("reboot_1", V_BOOT, 0, 0);
    step("reboot_2", V_BOOT, 0, 0);
    rst = 1'b1;
    step("rst_mid_boot", V_BOOT, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step("boot_restart", V_BOOT, 0, 0);
    step("run_after_restart", V_IDLE, 1, 0);
    check_cnt("cnt_after_restart");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
